// File: rtl/mdu_hilo_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide on magnitudes, sign fixed up in a final cycle.
module mdu_hilo_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Abort,
  input  logic             WrHi,
  input  logic             WrLo,
  input  logic [WIDTH-1:0] WrData,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_done, r_divzero;
  logic               r_is_div, r_neg_q, r_neg_r;
  logic [WIDTH-1:0]   r_opnd;
  logic [2*WIDTH-1:0] r_acc;

  logic               w_start, w_signed, w_dz, w_ge;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_rem_next, w_fix_hi, w_fix_lo;
  logic [WIDTH:0]     w_msum, w_shrem;
  logic [2*WIDTH-1:0] w_prod;

  function automatic logic [WIDTH-1:0] f_cneg(input logic neg, input logic [WIDTH-1:0] v);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] f_cneg2(input logic neg, input logic [2*WIDTH-1:0] v);
    return neg ? (~v + 1'b1) : v;
  endfunction

  assign w_start  = (r_state == S_IDLE) && Start;
  assign w_signed = ~Op[0];
  assign w_dz     = Op[1] && (B == '0);
  assign w_abs_a  = f_cneg(w_signed && A[WIDTH-1], A);
  assign w_abs_b  = f_cneg(w_signed && B[WIDTH-1], B);

  // Multiply step: add multiplicand into upper half when the current multiplier bit is set.
  assign w_msum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);

  // Divide step: remainder stays below the divisor, so the subtraction fits in WIDTH bits.
  assign w_shrem    = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_ge       = w_shrem >= {1'b0, r_opnd};
  assign w_rem_next = w_ge ? (w_shrem[WIDTH-1:0] - r_opnd) : w_shrem[WIDTH-1:0];

  assign w_prod   = f_cneg2(r_neg_q, r_acc);
  assign w_fix_hi = r_is_div ? f_cneg(r_neg_r, r_acc[2*WIDTH-1:WIDTH]) : w_prod[2*WIDTH-1:WIDTH];
  assign w_fix_lo = r_is_div ? f_cneg(r_neg_q, r_acc[WIDTH-1:0])       : w_prod[WIDTH-1:0];

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
      r_divzero <= 1'b0;
    end else if (Abort && (r_state != S_IDLE)) begin
      r_state   <= S_IDLE;
      r_done    <= 1'b0;
      r_divzero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (WrHi) r_hi <= WrData;
          if (WrLo) r_lo <= WrData;
          if (Start) begin
            r_cnt <= '0;
            if (w_dz) begin
              r_hi      <= A;
              r_lo      <= '1;
              r_divzero <= 1'b1;
              r_done    <= 1'b1;
              r_state   <= S_DONE;
            end else begin
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(WIDTH - 1)) r_state <= S_FIX;
        end
        S_FIX: begin
          r_hi    <= w_fix_hi;
          r_lo    <= w_fix_lo;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_divzero <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Datapath operands and accumulator carry no reset; they are always loaded on issue.
  always_ff @(posedge CLK) begin
    if (w_start) begin
      r_is_div <= Op[1];
      r_neg_q  <= w_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
      r_neg_r  <= w_signed && A[WIDTH-1];
      if (Op[1]) begin
        r_opnd <= w_abs_b;
        r_acc  <= {{WIDTH{1'b0}}, w_abs_a};
      end else begin
        r_opnd <= w_abs_a;
        r_acc  <= {{WIDTH{1'b0}}, w_abs_b};
      end
    end else if (r_state == S_CALC) begin
      r_acc <= r_is_div ? {w_rem_next, r_acc[WIDTH-2:0], w_ge}
                        : {w_msum, r_acc[WIDTH-1:1]};
    end
  end

  assign Busy    = (r_state != S_IDLE);
  assign Done    = r_done;
  assign DivZero = r_divzero;
  assign Hi      = r_hi;
  assign Lo      = r_lo;

endmodule

// File: tb/tb_mdu_hilo_unit.sv
// Self-checking bench for mdu_hilo_unit: directed cases, randomized ops against an arithmetic model.
module tb_mdu_hilo_unit;
  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         RSTn, Start, Abort, WrHi, WrLo;
  logic [1:0]   Op;
  logic [W-1:0] A, B, WrData;
  logic         Busy, Done, DivZero;
  logic [W-1:0] Hi, Lo;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] cur_hi, cur_lo;

  mdu_hilo_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .CLK(CLK), .RSTn(RSTn), .Start(Start), .Op(Op), .A(A), .B(B), .Abort(Abort),
    .WrHi(WrHi), .WrLo(WrLo), .WrData(WrData), .Busy(Busy), .Done(Done),
    .DivZero(DivZero), .Hi(Hi), .Lo(Lo)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference: plain 64-bit arithmetic; SV signed division truncates toward zero.
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo, output logic dz);
    longint       sa, sb, q, r;
    logic [63:0]  p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    hi = '0;
    lo = '0;
    case (op)
      2'd0: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
      2'd1: begin p = {32'b0, a} * {32'b0, b}; hi = p[63:32]; lo = p[31:0]; end
      default: begin
        if (b == 32'd0) begin
          dz = 1'b1; hi = a; lo = 32'hFFFFFFFF;
        end else if (op == 2'd2) begin
          q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0];
        end else begin
          lo = a / b; hi = a % b;
        end
      end
    endcase
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo, output logic dz,
                        output int lat, output logic post_done, output logic post_busy,
                        output logic post_dz);
    Start = 1'b1; Op = op; A = a; B = b;
    tick();
    Start = 1'b0;
    lat = 1;
    while (Done !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    hi = Hi; lo = Lo; dz = DivZero;
    tick();
    post_done = Done; post_busy = Busy; post_dz = DivZero;
  endtask

  task automatic test_reset();
    int dones;
    RSTn = 1'b0; Start = 1'b0; Abort = 1'b0; WrHi = 1'b0; WrLo = 1'b0;
    Op = 2'd0; A = '0; B = '0; WrData = '0;
    tick(); tick();
    n_checks++; if (Busy !== 1'b0)    begin n_fail++; $display("FAIL rst_busy: got %b exp 0", Busy); end
    n_checks++; if (Done !== 1'b0)    begin n_fail++; $display("FAIL rst_done: got %b exp 0", Done); end
    n_checks++; if (DivZero !== 1'b0) begin n_fail++; $display("FAIL rst_divzero: got %b exp 0", DivZero); end
    n_checks++; if (Hi !== 32'h0)     begin n_fail++; $display("FAIL rst_hi: got %h exp 0", Hi); end
    n_checks++; if (Lo !== 32'h0)     begin n_fail++; $display("FAIL rst_lo: got %h exp 0", Lo); end
    RSTn = 1'b1;
    tick();
    WrHi = 1'b1; WrLo = 1'b1; WrData = 32'hA5A50001;
    tick();
    WrHi = 1'b0; WrLo = 1'b0;
    n_checks++; if (Hi !== 32'hA5A50001) begin n_fail++; $display("FAIL rst_prewrite_hi: got %h exp a5a50001", Hi); end
    Start = 1'b1; Op = 2'd2; A = 32'd1000; B = 32'd7;
    tick();
    Start = 1'b0;
    repeat (9) tick();
    RSTn = 1'b0;
    tick();
    RSTn = 1'b1;
    n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b exp 0", Busy); end
    n_checks++; if (Hi !== 32'h0)  begin n_fail++; $display("FAIL rst_mid_hi: got %h exp 0", Hi); end
    n_checks++; if (Lo !== 32'h0)  begin n_fail++; $display("FAIL rst_mid_lo: got %h exp 0", Lo); end
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (Done === 1'b1) dones++;
    end
    n_checks++; if (dones != 0) begin n_fail++; $display("FAIL rst_mid_nodone: got %0d pulses exp 0", dones); end
    cur_hi = '0; cur_lo = '0;
  endtask

  task automatic test_directed();
    logic [1:0]  t_op [5];
    logic [31:0] t_a [5], t_b [5], t_hi [5], t_lo [5];
    logic        t_dz [5];
    int          t_lat [5];
    logic [31:0] hi, lo;
    logic        dz, pd, pb, pz;
    int          lat;
    t_op  = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd3};
    t_a   = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'h80000000, 32'd100};
    t_b   = '{32'd7, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'd0};
    t_hi  = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000, 32'd100};
    t_lo  = '{32'hFFFFFFEB, 32'h00000001, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF};
    t_dz  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    t_lat = '{34, 34, 34, 34, 1};
    for (int i = 0; i < 5; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], hi, lo, dz, lat, pd, pb, pz);
      n_checks++; if (hi !== t_hi[i])   begin n_fail++; $display("FAIL dir%0d_hi: got %h exp %h", i, hi, t_hi[i]); end
      n_checks++; if (lo !== t_lo[i])   begin n_fail++; $display("FAIL dir%0d_lo: got %h exp %h", i, lo, t_lo[i]); end
      n_checks++; if (dz !== t_dz[i])   begin n_fail++; $display("FAIL dir%0d_divzero: got %b exp %b", i, dz, t_dz[i]); end
      n_checks++; if (lat != t_lat[i])  begin n_fail++; $display("FAIL dir%0d_latency: got %0d exp %0d", i, lat, t_lat[i]); end
      n_checks++; if (pd !== 1'b0 || pb !== 1'b0 || pz !== 1'b0)
        begin n_fail++; $display("FAIL dir%0d_after_done: got done=%b busy=%b dz=%b exp 0/0/0", i, pd, pb, pz); end
      cur_hi = t_hi[i]; cur_lo = t_lo[i];
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, hi, lo, ehi, elo;
    logic [1:0]  op;
    logic        dz, edz, pd, pb, pz;
    int          lat;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: begin a = 32'h80000000; b = ($urandom_range(0, 1) == 0) ? 32'hFFFFFFFF : 32'd1; end
        3: a = 32'($urandom_range(0, 255));
        default: ;
      endcase
      model(op, a, b, ehi, elo, edz);
      run_op(op, a, b, hi, lo, dz, lat, pd, pb, pz);
      n_checks++; if (hi !== ehi) begin n_fail++; $display("FAIL rnd%0d_hi op=%0d a=%h b=%h: got %h exp %h", i, op, a, b, hi, ehi); end
      n_checks++; if (lo !== elo) begin n_fail++; $display("FAIL rnd%0d_lo op=%0d a=%h b=%h: got %h exp %h", i, op, a, b, lo, elo); end
      n_checks++; if (dz !== edz) begin n_fail++; $display("FAIL rnd%0d_divzero: got %b exp %b", i, dz, edz); end
      n_checks++; if (lat != (edz ? 1 : 34)) begin n_fail++; $display("FAIL rnd%0d_latency: got %0d exp %0d", i, lat, edz ? 1 : 34); end
      cur_hi = ehi; cur_lo = elo;
    end
  endtask

  task automatic test_mthi_mtlo();
    int n;
    WrHi = 1'b1; WrData = 32'h00001111;
    tick();
    WrHi = 1'b0;
    n_checks++; if (Hi !== 32'h00001111 || Lo !== cur_lo)
      begin n_fail++; $display("FAIL mthi: got hi=%h lo=%h exp hi=00001111 lo=%h", Hi, Lo, cur_lo); end
    WrLo = 1'b1; WrData = 32'h00002222;
    tick();
    WrLo = 1'b0;
    n_checks++; if (Hi !== 32'h00001111 || Lo !== 32'h00002222)
      begin n_fail++; $display("FAIL mtlo: got hi=%h lo=%h exp 00001111/00002222", Hi, Lo); end
    WrHi = 1'b1; WrLo = 1'b1; WrData = 32'h00003333;
    tick();
    WrHi = 1'b0; WrLo = 1'b0;
    n_checks++; if (Hi !== 32'h00003333 || Lo !== 32'h00003333)
      begin n_fail++; $display("FAIL mthilo_both: got hi=%h lo=%h exp 00003333/00003333", Hi, Lo); end
    Start = 1'b1; Op = 2'd1; A = 32'd3; B = 32'd4; WrHi = 1'b1; WrData = 32'h00004444;
    tick();
    Start = 1'b0; WrHi = 1'b0;
    n_checks++; if (Hi !== 32'h00004444 || Busy !== 1'b1)
      begin n_fail++; $display("FAIL write_with_start: got hi=%h busy=%b exp 00004444/1", Hi, Busy); end
    WrHi = 1'b1; WrLo = 1'b1; WrData = 32'd5;
    repeat (5) tick();
    WrHi = 1'b0; WrLo = 1'b0;
    n_checks++; if (Hi !== 32'h00004444 || Lo !== 32'h00003333)
      begin n_fail++; $display("FAIL write_while_busy: got hi=%h lo=%h exp 00004444/00003333", Hi, Lo); end
    n = 0;
    while (Done !== 1'b1 && n < 100) begin tick(); n++; end
    n_checks++; if (Hi !== 32'd0 || Lo !== 32'd12)
      begin n_fail++; $display("FAIL busy_write_result: got hi=%h lo=%h exp 0/0000000c", Hi, Lo); end
    tick();
    cur_hi = 32'd0; cur_lo = 32'd12;
  endtask

  task automatic test_back_to_back();
    int          dones;
    logic [31:0] hi, lo, a, b, ehi, elo;
    logic        dz, edz, pd, pb, pz;
    int          lat;
    dones = 0; hi = 'x; lo = 'x;
    Start = 1'b1; Op = 2'd1; A = 32'd6; B = 32'd7;
    for (int i = 0; i < 35; i++) begin
      tick();
      if (Done === 1'b1) begin dones++; hi = Hi; lo = Lo; end
    end
    Start = 1'b0;
    n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL start_held_busy: got %b exp 0", Busy); end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (Done === 1'b1) dones++;
    end
    n_checks++; if (dones != 1) begin n_fail++; $display("FAIL start_held_dones: got %0d exp 1", dones); end
    n_checks++; if (hi !== 32'd0 || lo !== 32'd42)
      begin n_fail++; $display("FAIL start_held_result: got hi=%h lo=%h exp 0/0000002a", hi, lo); end
    for (int i = 0; i < 3; i++) begin
      a = $urandom; b = $urandom;
      model(2'd0, a, b, ehi, elo, edz);
      run_op(2'd0, a, b, hi, lo, dz, lat, pd, pb, pz);
      n_checks++; if (hi !== ehi || lo !== elo)
        begin n_fail++; $display("FAIL b2b%0d: got %h_%h exp %h_%h", i, hi, lo, ehi, elo); end
      cur_hi = ehi; cur_lo = elo;
    end
  endtask

  task automatic test_abort();
    int dones, n;
    Start = 1'b1; Op = 2'd2; A = $urandom; B = 32'($urandom_range(1, 1000));
    tick();
    Start = 1'b0;
    repeat (19) tick();
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b exp 0", Busy); end
    n_checks++; if (Hi !== cur_hi || Lo !== cur_lo)
      begin n_fail++; $display("FAIL abort_hilo: got %h_%h exp %h_%h", Hi, Lo, cur_hi, cur_lo); end
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (Done === 1'b1) dones++;
    end
    n_checks++; if (dones != 0) begin n_fail++; $display("FAIL abort_nodone: got %0d exp 0", dones); end
    Abort = 1'b1; Start = 1'b1; Op = 2'd1; A = 32'd2; B = 32'd3;
    tick();
    Abort = 1'b0; Start = 1'b0;
    n_checks++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL abort_idle_start: got busy=%b exp 1", Busy); end
    n = 0;
    while (Done !== 1'b1 && n < 100) begin tick(); n++; end
    n_checks++; if (Hi !== 32'd0 || Lo !== 32'd6)
      begin n_fail++; $display("FAIL abort_idle_result: got %h_%h exp 0/00000006", Hi, Lo); end
    tick();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_mthi_mtlo();
    test_back_to_back();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_hilo_unit.md
Name: mdu_hilo_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers.
- Sits beside the EX stage of the 5-stage pipeline. EX issues MULT/MULTU/DIV/DIVU operands taken from the ID/EX rd1/rd2 outputs.
- The hazard logic stalls IF/ID/EX while Busy is high. MFHI/MFLO read Hi/Lo directly.
- Replaces a single-cycle array multiplier to keep the EX critical path short.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- CLK  input  1  rising-edge clock
- RSTn  input  1  synchronous active-low reset
- Start  input  1  issue request; sampled on CLK rising edge
- Op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- A  input  WIDTH  rs operand (dividend / multiplicand)
- B  input  WIDTH  rt operand (divisor / multiplier)
- Abort  input  1  cancel in-flight operation (pipeline flush)
- WrHi  input  1  MTHI write strobe
- WrLo  input  1  MTLO write strobe
- WrData  input  WIDTH  MTHI/MTLO data
- Busy  output  1  high whenever state != IDLE
- Done  output  1  one-cycle pulse; result valid in Hi/Lo
- DivZero  output  1  qualifies Done: divisor was zero
- Hi  output  WIDTH  HI register
- Lo  output  WIDTH  LO register

Behaviour:
- Reset (RSTn=0 at an edge): state IDLE, Hi=0, Lo=0, Done=0, DivZero=0, Busy=0, counter=0. This applies mid-operation too; the in-flight operation is discarded.
- Reset has priority over Abort, which has priority over everything else.
- States: IDLE, CALC, FIX, DONE.
- IDLE, Start=1 at edge E0:
  - Latch Op.
  - For signed ops, latch |A| and |B| plus the result sign flags.
  - Clear the partial accumulator and set counter=0.
  - Next state is CALC. The one exception is DIV/DIVU with B==0, which goes to DONE with Hi=A, Lo={WIDTH{1}}, DivZero=1.
- CALC: one iteration per edge, WIDTH edges (E1..E32), then FIX.
  - Multiply is shift-add over a 2*WIDTH product.
  - Divide is restoring: shift remainder, trial subtract, set quotient bit.
- FIX (edge E33): apply sign correction, then write Hi/Lo and go to DONE.
  - Multiply: negate the 64-bit product if the sign flags differ. Hi = upper half, Lo = lower half.
  - Divide: quotient truncates toward zero and takes its sign from sign(A) xor sign(B). Remainder takes the sign of A. Hi = remainder, Lo = quotient.
  - Overflow case -2^31 / -1: Lo=32'h80000000, Hi=0, no flag.
- DONE: Done=1 for exactly this cycle, then IDLE on the next edge. DivZero is cleared on leaving DONE.
- Latency: Start at E0 gives Done high in the cycle after E33, which is 34 cycles. The divide-by-zero path gives Done in the cycle after E0.
- Busy: combinational from state and high in CALC, FIX and DONE. Start is ignored while Busy=1, including in the DONE cycle.
- Abort=1 at an edge while Busy: go to IDLE. Hi/Lo are unchanged and no Done pulse is produced. Abort in IDLE has no effect.
- WrHi/WrLo: take effect only in IDLE and are ignored while Busy.
  - WrHi together with WrLo writes both registers.
  - When Start and WrHi/WrLo arrive at the same edge, the write happens first and the operation still starts.
- Hi/Lo change only on reset, FIX, the divide-by-zero entry edge, or an accepted MTHI/MTLO.
- Unsigned ops use operands as-is, with no sign handling.

Test Plan:
- Reset during CALC (cycle 10 of a DIV) -> next cycle Busy=0, Hi=0, Lo=0, Done never pulses.
- MULT A=-3 (32'hFFFFFFFD), B=7 -> Done at cycle 34, Hi=32'hFFFFFFFF, Lo=32'hFFFFFFEB.
- MULTU A=32'hFFFFFFFF, B=32'hFFFFFFFF -> Hi=32'hFFFFFFFE, Lo=32'h00000001.
- DIV A=-7, B=2 -> Lo=32'hFFFFFFFD (-3), Hi=32'hFFFFFFFF (-1). DIV A=32'h80000000, B=-1 -> Lo=32'h80000000, Hi=0.
- DIVU A=100, B=0 -> Done one cycle after Start, DivZero=1, Hi=100, Lo=32'hFFFFFFFF.
- Back-to-back and handshake:
  - Start held high through an entire MULTU 6*7 -> exactly one Done, Hi=0, Lo=42.
  - WrHi=1, WrData=5 while Busy -> Hi unchanged.
  - Abort at cycle 20 -> Busy=0 next cycle, Hi/Lo keep their prior values.
